ecpri_tx_framer: RTL and testbench
==================================

Name: ecpri_tx_framer

Overview:
Drains eCPRI payload bytes from the byte FIFO and emits a complete eCPRI message as a byte stream. Prepends the 4-byte eCPRI common header before the payload. Sits between the payload FIFO's read port and the fronthaul transmit path. Handles downstream backpressure without losing FIFO data.

Parameters:
REVISION, 4'h1, eCPRI protocol revision placed in header byte0[7:4]
MAX_PAYLOAD, 16'd1024, largest payload_len accepted; larger requests are rejected

Ports:
out_clk  input  1  single clock; all logic on posedge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle frame request, sampled only in IDLE
msg_type  input  8  eCPRI message type, captured on accepted start
payload_len  input  16  payload byte count, captured on accepted start
busy  output  1  high from accepted start until the eop byte is accepted
req_err  output  1  one-cycle pulse when start is rejected
fifo_rd  output  1  FIFO read strobe; data valid on fifo_d the following cycle
fifo_d  input  8  FIFO read data
fifo_empty  input  1  FIFO has no data; fifo_rd never asserted while high
tx_d  output  8  stream byte
tx_valid  output  1  tx_d valid
tx_sop  output  1  first header byte of a message
tx_eop  output  1  last byte of a message
tx_ready  input  1  downstream accepts the byte when tx_valid && tx_ready

Behaviour:
- Interface fixed: one clock (out_clk); reset is asynchronous and active-low (reset).
- Reset (reset=0, any time): state=IDLE; busy, req_err, fifo_rd, tx_valid, tx_sop, tx_eop=0; tx_d=0; skid buffer emptied; counters=0. A frame in flight is truncated with no eop. Outstanding FIFO data is discarded.
- Header bytes, big-endian:
  - byte0 = {REVISION, 3'b000, 1'b0}. C bit is 0, one message per frame.
  - byte1 = msg_type.
  - byte2 = payload_len[15:8].
  - byte3 = payload_len[7:0].
- States:
  - IDLE: on start, accept if payload_len <= MAX_PAYLOAD. Capture fields, busy=1, go to HDR. Otherwise pulse req_err next cycle and stay in IDLE.
  - HDR: present bytes 0..3, each advancing on handshake. After byte3 is accepted, go to PAY. If payload_len=0, byte3 carries tx_eop and the next state is IDLE.
  - PAY: stream payload_len FIFO bytes. The last byte carries tx_eop. When it is accepted, go to IDLE and set busy=0.
- start while busy: ignored, no req_err.
- Output stage is a 2-entry skid buffer. tx_valid=1 whenever the buffer is non-empty. tx_d, tx_sop and tx_eop stay stable while tx_valid && !tx_ready.
- fifo_rd=1 only when all of the following hold:
  - state is PAY;
  - remaining-to-read > 0;
  - !fifo_empty;
  - (skid occupancy + reads in flight) < 2.
- Each fifo_rd decrements a 16-bit remaining-to-read counter. Data returned one cycle later is written into the skid buffer unconditionally, so no data is lost.
- Throughput: 1 byte/cycle when tx_ready is held high and the FIFO is non-empty. First payload byte appears no earlier than 1 cycle after the byte3 handshake.
- FIFO underrun mid-frame (fifo_empty high): tx_valid drops once the buffer drains. The frame resumes when data arrives; no error is flagged.
- No header or payload byte is ever duplicated or skipped under arbitrary tx_ready patterns.

Optional Feature:
Macro: ECPRI_TX_STATS_EN
- Defined: adds output tx_frame_cnt[15:0]. Reset to 0; increments by 1 on each accepted eop byte; wraps 16'hFFFF -> 0. Adds output tx_stall_cnt[15:0], which counts cycles with tx_valid && !tx_ready, saturating at 16'hFFFF.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, then start with msg_type=8'h00, payload_len=3, FIFO preloaded AA BB CC, tx_ready=1 -> stream 10 00 00 03 AA BB CC. sop on 8'h10, eop on 8'hCC, busy drops after eop.
- start with payload_len=0, msg_type=8'h02 -> 4 bytes 10 02 00 00, with sop and eop both seen (eop on byte3). fifo_rd never asserted.
- payload_len=8, tx_ready toggled 1/0 every cycle -> all 12 bytes delivered in order, tx_d held stable while not ready, fifo_rd never asserted with skid full.
- payload_len=1025 with MAX_PAYLOAD=1024 -> req_err pulses once, busy stays 0, no tx_valid.
- payload_len=4, fifo_empty held high for 5 cycles after the header -> tx_valid low during the gap, then 4 bytes arrive, eop on the last.
- Reset asserted mid-payload -> all outputs 0 asynchronously. A subsequent start with payload_len=2 produces a clean 6-byte frame. With ECPRI_TX_STATS_EN defined, tx_frame_cnt=1 after that frame.

Source files
------------

// File: rtl/ecpri_tx_framer.sv
// eCPRI transmit framer: prepends the 4-byte common header to FIFO payload and streams it out
// through a 2-entry skid buffer. Define ECPRI_TX_STATS_EN to add frame and stall counters.
module ecpri_tx_framer #(
    parameter logic [3:0]  REVISION    = 4'h1,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1024
) (
    input  logic        out_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  msg_type,
    input  logic [15:0] payload_len,
    output logic        busy,
    output logic        req_err,
    output logic        fifo_rd,
    input  logic [7:0]  fifo_d,
    input  logic        fifo_empty,
    output logic [7:0]  tx_d,
    output logic        tx_valid,
    output logic        tx_sop,
    output logic        tx_eop,
    input  logic        tx_ready
`ifdef ECPRI_TX_STATS_EN
    ,
    output logic [15:0] tx_frame_cnt,
    output logic [15:0] tx_stall_cnt
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY} state_e;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } beat_t;

    state_e      state_q, state_d;
    logic [7:0]  type_q, type_d;
    logic [15:0] len_q, len_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] rem_q, rem_d;
    logic        req_err_q, req_err_d;
    logic        rd_inflight_q, rd_last_q;
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  cnt_q;
    beat_t       skid_q [2];

    beat_t       head, push_beat;
    logic [7:0]  hdr_byte;
    logic        pop, push_hdr, push, fifo_rd_w;
    logic [1:0]  cnt_after_pop;

    assign head     = skid_q[rd_ptr_q];
    assign tx_valid = (cnt_q != 2'd0);
    assign pop      = tx_valid && tx_ready;
    assign push_hdr = (state_q == ST_HDR) && !hdr_idx_q[2] && (cnt_q != 2'd2);
    assign push     = push_hdr || rd_inflight_q;

    // Room is judged after this cycle's pop so a steady stream sustains one byte per cycle.
    assign cnt_after_pop = cnt_q - {1'b0, pop};
    assign fifo_rd_w = (state_q == ST_PAY) && (rem_q != 16'd0) && !fifo_empty &&
                       (cnt_q != 2'd2) && ((cnt_after_pop + {1'b0, rd_inflight_q}) < 2'd2);

    always_comb begin
        case (hdr_idx_q[1:0])
            2'd0:    hdr_byte = {REVISION, 4'b0000};
            2'd1:    hdr_byte = type_q;
            2'd2:    hdr_byte = len_q[15:8];
            default: hdr_byte = len_q[7:0];
        endcase
    end

    always_comb begin
        push_beat = '0;
        if (rd_inflight_q) begin
            push_beat.data = fifo_d;
            push_beat.eop  = rd_last_q;
        end else if (push_hdr) begin
            push_beat.data = hdr_byte;
            push_beat.sop  = (hdr_idx_q == 3'd0);
            push_beat.eop  = (hdr_idx_q == 3'd3) && (len_q == 16'd0);
        end
    end

    // NOTE: every next-state signal is defaulted first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        len_d     = len_q;
        hdr_idx_d = hdr_idx_q;
        rem_d     = rem_q;
        req_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (payload_len <= MAX_PAYLOAD) begin
                        type_d    = msg_type;
                        len_d     = payload_len;
                        rem_d     = payload_len;
                        hdr_idx_d = 3'd0;
                        state_d   = ST_HDR;
                    end else begin
                        req_err_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (push_hdr) hdr_idx_d = hdr_idx_q + 3'd1;
                // All four bytes queued and the last one leaving means byte3 was just accepted.
                if (hdr_idx_q[2] && pop && (cnt_q == 2'd1)) begin
                    state_d = (len_q == 16'd0) ? ST_IDLE : ST_PAY;
                end
            end
            ST_PAY: begin
                if (fifo_rd_w) rem_d = rem_q - 16'd1;
                if (pop && head.eop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the skid entries drive tx_d, so they are reset along with the control state.
    always_ff @(posedge out_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            type_q        <= '0;
            len_q         <= '0;
            hdr_idx_q     <= '0;
            rem_q         <= '0;
            req_err_q     <= 1'b0;
            rd_inflight_q <= 1'b0;
            rd_last_q     <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= '0;
            for (int i = 0; i < 2; i++) skid_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            len_q         <= len_d;
            hdr_idx_q     <= hdr_idx_d;
            rem_q         <= rem_d;
            req_err_q     <= req_err_d;
            rd_inflight_q <= fifo_rd_w;
            rd_last_q     <= fifo_rd_w && (rem_q == 16'd1);
            if (push) begin
                skid_q[wr_ptr_q] <= push_beat;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign req_err = req_err_q;
    assign fifo_rd = fifo_rd_w;
    assign tx_d    = tx_valid ? head.data : 8'h00;
    assign tx_sop  = tx_valid && head.sop;
    assign tx_eop  = tx_valid && head.eop;

`ifdef ECPRI_TX_STATS_EN
    logic [15:0] frame_cnt_q, stall_cnt_q;

    always_ff @(posedge out_clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop && head.eop) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (tx_valid && !tx_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign tx_frame_cnt = frame_cnt_q;
    assign tx_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ecpri_tx_framer.sv
// Scoreboard bench for ecpri_tx_framer: a FIFO model feeds random payload, expected bytes are
// queued at request time and a negedge monitor compares every accepted output byte.
module tb_ecpri_tx_framer;

    logic        out_clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  msg_type = 8'h00;
    logic [15:0] payload_len = 16'h0000;
    logic        busy, req_err, fifo_rd;
    logic [7:0]  fifo_d = 8'h00;
    logic        fifo_empty = 1'b1;
    logic [7:0]  tx_d;
    logic        tx_valid, tx_sop, tx_eop;
    logic        tx_ready = 1'b0;
`ifdef ECPRI_TX_STATS_EN
    logic [15:0] tx_frame_cnt, tx_stall_cnt;
`endif

    ecpri_tx_framer dut (
        .out_clk     (out_clk),
        .reset       (reset),
        .start       (start),
        .msg_type    (msg_type),
        .payload_len (payload_len),
        .busy        (busy),
        .req_err     (req_err),
        .fifo_rd     (fifo_rd),
        .fifo_d      (fifo_d),
        .fifo_empty  (fifo_empty),
        .tx_d        (tx_d),
        .tx_valid    (tx_valid),
        .tx_sop      (tx_sop),
        .tx_eop      (tx_eop),
        .tx_ready    (tx_ready)
`ifdef ECPRI_TX_STATS_EN
        ,
        .tx_frame_cnt(tx_frame_cnt),
        .tx_stall_cnt(tx_stall_cnt)
`endif
    );

    always #5 out_clk = ~out_clk;

    typedef struct packed {
        logic       pay;
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] pl_q[$];
    logic [7:0] held_q[$];

    int         checks = 0;
    int         passes = 0;
    int         ready_mode = 0;
    bit         rd_pending = 1'b0;
    logic [7:0] rd_byte = 8'h00;
    int         rd_allow = 0;
    int         outstanding = 0;
    int         req_err_seen = 0;
    int         req_err_exp = 0;
    bit         hold_v = 1'b0;
    logic [9:0] hold_b = '0;
    bit         expect_idle = 1'b0;
    int         eop_cnt = 0;
    int         stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // FIFO and downstream model: read data appears the cycle after the strobe.
    always @(posedge out_clk) begin
        #1;
        if (rd_pending) fifo_d = rd_byte;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        fifo_empty = (fifo_q.size() == 0);
    end

    always @(negedge out_clk) begin
        if (!reset) begin
            rd_pending  = 1'b0;
            hold_v      = 1'b0;
            expect_idle = 1'b0;
        end else begin
            exp_t e;
            bit   pay_hs;
            pay_hs = tx_valid && tx_ready && (exp_q.size() > 0) && exp_q[0].pay;
            if (expect_idle) check("busy_after_eop", busy, 0);
            expect_idle = 1'b0;
            if (req_err) req_err_seen++;
            if (hold_v) check("hold_stable", {tx_valid, tx_d, tx_sop, tx_eop}, {1'b1, hold_b});
            hold_v = 1'b0;
            rd_pending = 1'b0;
            if (fifo_rd) begin
                check("rd_not_empty", fifo_empty, 0);
                check("rd_within_len", rd_allow > 0, 1);
                check("rd_skid_room", (outstanding - int'(pay_hs)) <= 1, 1);
                rd_allow--;
                outstanding++;
                if (fifo_q.size() > 0) begin
                    rd_byte    = fifo_q.pop_front();
                    rd_pending = 1'b1;
                end
            end
            if (tx_valid && tx_ready) begin
                check("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tx_byte", {tx_d, tx_sop, tx_eop}, {e.d, e.sop, e.eop});
                    if (e.pay) outstanding--;
                    if (tx_eop) begin
                        expect_idle = 1'b1;
                        eop_cnt++;
                    end
                end
            end else if (tx_valid) begin
                hold_v = 1'b1;
                hold_b = {tx_d, tx_sop, tx_eop};
                stall_cnt++;
            end
        end
    end

    task automatic pulse_start(input logic [7:0] t, input logic [15:0] len);
        @(posedge out_clk);
        #2;
        start       = 1'b1;
        msg_type    = t;
        payload_len = len;
        @(posedge out_clk);
        #2;
        start = 1'b0;
    endtask

    // Queues the expected message; payload comes from pl_q if it matches len, else random.
    task automatic issue_frame(input logic [7:0] t, input int len, input bit hold_payload);
        logic [15:0] l;
        l = 16'(len);
        if (pl_q.size() != len) begin
            pl_q.delete();
            for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
        end
        exp_q.push_back('{pay: 1'b0, d: 8'h10, sop: 1'b1, eop: 1'b0});
        exp_q.push_back('{pay: 1'b0, d: t, sop: 1'b0, eop: 1'b0});
        exp_q.push_back('{pay: 1'b0, d: l[15:8], sop: 1'b0, eop: 1'b0});
        exp_q.push_back('{pay: 1'b0, d: l[7:0], sop: 1'b0, eop: (len == 0)});
        held_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{pay: 1'b1, d: pl_q[i], sop: 1'b0, eop: (i == len - 1)});
            if (hold_payload) held_q.push_back(pl_q[i]);
            else fifo_q.push_back(pl_q[i]);
        end
        pl_q.delete();
        rd_allow = len;
        pulse_start(t, l);
        @(negedge out_clk);
        check("busy_set", busy, 1);
    endtask

    task automatic wait_frame();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 5000) begin
            @(negedge out_clk);
            guard++;
        end
        check("frame_done_in_time", guard < 5000, 1);
        @(negedge out_clk);
        check("all_payload_read", rd_allow, 0);
    endtask

    task automatic run_frame(input logic [7:0] t, input int len, input bit poke);
        issue_frame(t, len, 1'b0);
        if (poke) begin
            pulse_start(8'h55, 16'd2000);
            pulse_start(8'h66, 16'd5);
        end
        wait_frame();
    endtask

    initial begin
        #100000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ready_mode = 0;
        repeat (3) @(posedge out_clk);
        #1;
        check("reset_outputs", {busy, req_err, fifo_rd, tx_valid, tx_sop, tx_eop, tx_d}, 0);
        @(negedge out_clk);
        reset = 1'b1;

        pl_q = '{8'hAA, 8'hBB, 8'hCC};
        run_frame(8'h00, 3, 1'b0);

        run_frame(8'h02, 0, 1'b0);

        ready_mode = 1;
        run_frame(8'h21, 8, 1'b0);

        ready_mode = 0;
        pulse_start(8'h07, 16'd1025);
        req_err_exp++;
        @(negedge out_clk);
        check("req_err_pulse", req_err, 1);
        repeat (3) begin
            @(negedge out_clk);
            check("req_err_single", req_err, 0);
            check("rejected_idle", {busy, tx_valid}, 0);
        end

        issue_frame(8'h33, 4, 1'b1);
        for (int g = 0; g < 200 && exp_q.size() > 4; g++) @(posedge out_clk);
        repeat (5) begin
            @(negedge out_clk);
            check("gap_no_valid", tx_valid, 0);
        end
        while (held_q.size() > 0) fifo_q.push_back(held_q.pop_front());
        wait_frame();

        ready_mode = 2;
        run_frame(8'h44, 1024, 1'b0);
        run_frame(8'h45, 5, 1'b1);

        for (int n = 0; n < 12; n++) begin
            ready_mode = int'($urandom_range(0, 2));
            run_frame(8'($urandom), (n % 4 == 0) ? 0 : int'($urandom_range(1, 24)), 1'($urandom_range(0, 1)));
        end

        ready_mode = 2;
        issue_frame(8'h77, 8, 1'b0);
        for (int g = 0; g < 300 && exp_q.size() > 4; g++) @(posedge out_clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {busy, req_err, fifo_rd, tx_valid, tx_sop, tx_eop, tx_d}, 0);
        exp_q.delete();
        fifo_q.delete();
        rd_allow    = 0;
        outstanding = 0;
        eop_cnt     = 0;
        stall_cnt   = 0;
        repeat (2) @(posedge out_clk);
        @(negedge out_clk);
        check("reset_held_outputs", {busy, tx_valid, fifo_rd, tx_d}, 0);
        reset = 1'b1;
        run_frame(8'h12, 2, 1'b0);
`ifdef ECPRI_TX_STATS_EN
        check("frame_cnt", tx_frame_cnt, 32'(eop_cnt));
        check("frame_cnt_one", tx_frame_cnt, 1);
        check("stall_cnt", tx_stall_cnt, 32'(stall_cnt));
`endif

        check("req_err_total", req_err_seen, req_err_exp);
        check("fifo_drained", fifo_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
